// File: rtl/fsm2.sv
// fsm2: two-state Moore machine with JK flip-flop behaviour.
// j sets the output, k clears it, and j together with k toggles it.
// cstate and nstate are probed hierarchically, so their names and widths must stay fixed.
module fsm2 #(
    parameter logic OFF_ENC = 1'b0,
    parameter logic ON_ENC  = 1'b1   // must differ from OFF_ENC
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic j,
    input  logic k,
    output logic out
);

    logic cstate;
    logic nstate;

    // State register: async clear to OFF, otherwise load next state each rising edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cstate <= OFF_ENC;
        end else begin
            cstate <= nstate;
        end
    end

    // Next-state logic: JK semantics; an unrecognised encoding recovers to OFF.
    always_comb begin
        nstate = cstate;
        case (cstate)
            OFF_ENC: nstate = j ? ON_ENC : OFF_ENC;
            ON_ENC:  nstate = k ? OFF_ENC : ON_ENC;
            default: nstate = OFF_ENC;
        endcase
    end

    // Output logic: Moore output, a function of cstate only.
    always_comb begin
        out = 1'b0;
        case (cstate)
            OFF_ENC: out = 1'b0;
            ON_ENC:  out = 1'b1;
            default: out = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_fsm2.sv
// tb_fsm2: directed self-checking bench for fsm2 with hand-computed expectations.
module tb_fsm2;

    logic sys_clk;
    logic sys_rst_n;
    logic j;
    logic k;
    logic out;

    int n_checks;
    int n_fail;

    fsm2 dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .j         (j),
        .k         (k),
        .out       (out)
    );

    // 10 ns clock; rising edges fall at 5, 15, 25, ...
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Apply {j,k} after a falling edge, check nstate before the next rising edge, then check
    // out and cstate after that edge.
    task automatic step(input string tag, input logic jv, input logic kv,
                        input logic exp_n, input logic exp_o);
        @(negedge sys_clk);
        j = jv;
        k = kv;
        #1;
        check_bit({tag, ".nstate"}, dut.nstate, exp_n);
        @(posedge sys_clk);
        #1;
        check_bit({tag, ".out"}, out, exp_o);
        check_bit({tag, ".cstate"}, dut.cstate, exp_o);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        sys_rst_n = 1'b0;
        j         = 1'b0;
        k         = 1'b0;

        // Reset held for 20 ns; out must stay 0 across the clock edges at 5 and 15.
        #2;
        check_bit("rst.out_t2", out, 1'b0);
        check_bit("rst.cstate_t2", dut.cstate, 1'b0);
        @(posedge sys_clk);
        #1;
        check_bit("rst.out_edge1", out, 1'b0);
        // j=1 while reset is held must still be ignored at the clock edge.
        j = 1'b1;
        @(posedge sys_clk);
        #1;
        check_bit("rst.out_edge2_j1", out, 1'b0);
        check_bit("rst.cstate_edge2_j1", dut.cstate, 1'b0);
        j = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        #1;
        check_bit("rel.out", out, 1'b0);

        // Sequence {j,k} = 10, 00, 11, 01 gives out = 1, 1, 0, 0.
        step("s10", 1'b1, 1'b0, 1'b1, 1'b1);
        step("s00", 1'b0, 1'b0, 1'b1, 1'b1);
        step("s11_on", 1'b1, 1'b1, 1'b0, 1'b0);
        step("s01_off", 1'b0, 1'b1, 1'b0, 1'b0);
        // Toggle from OFF, then hold with j=1 while ON.
        step("s11_off", 1'b1, 1'b1, 1'b1, 1'b1);
        step("s10_on", 1'b1, 1'b0, 1'b1, 1'b1);
        step("s00_on", 1'b0, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset between edges while ON: out drops before any rising edge.
        @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_bit("async.out", out, 1'b0);
        check_bit("async.cstate", dut.cstate, 1'b0);
        j = 1'b1;
        @(posedge sys_clk);
        #1;
        check_bit("async.held_edge", out, 1'b0);
        @(negedge sys_clk);
        j = 1'b0;
        sys_rst_n = 1'b1;
        step("post_rst00", 1'b0, 1'b0, 1'b0, 1'b0);
        step("post_rst01", 1'b0, 1'b1, 1'b0, 1'b0);
        step("post_rst10", 1'b1, 1'b0, 1'b1, 1'b1);
        step("post_rst01_on", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fsm2.md
Name: fsm2

Overview:
- Two-state Moore machine with JK flip-flop semantics: j turns the output on, k turns it off.
- State is held in one register, `cstate`. Next state is a separate combinational signal, `nstate`.
- Control-path utility block with one clock domain and one output bit.
- Hierarchical monitors probe `cstate` and `nstate` directly, so both names and widths are fixed.

Parameters:
- OFF_ENC, 1'b0, encoding of state OFF.
- ON_ENC, 1'b1, encoding of state ON. Must differ from OFF_ENC.

Ports:
- sys_clk  input  1  system clock; all state updates occur on its rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- j  input  1  set request; sampled at the rising edge of sys_clk.
- k  input  1  clear request; sampled at the rising edge of sys_clk.
- out  output  1  Moore output; 1 while in state ON.

Behaviour:
- Internal signals, mandatory names, each 1 bit wide:
  - `cstate`: the state register.
  - `nstate`: combinational next state.
- States: OFF (OFF_ENC) and ON (ON_ENC).
- Reset:
  - sys_rst_n low forces `cstate` to OFF immediately, without waiting for a clock edge.
  - `out` is therefore 0 during reset and after it.
  - While reset is held low, the register ignores clock edges.
  - Release takes effect on the first rising edge of sys_clk after sys_rst_n goes high.
- Transitions (`nstate` is a pure combinational function of `cstate`, j and k):
  - OFF, j=0 → OFF, regardless of k.
  - OFF, j=1 → ON, regardless of k.
  - ON, k=0 → ON, regardless of j.
  - ON, k=1 → OFF, regardless of j.
- Simultaneous j=1 and k=1 toggles the state: OFF goes to ON, ON goes to OFF.
- Register update: `cstate` <= `nstate` on each rising edge of sys_clk while sys_rst_n is high.
- Output:
  - out = 1 exactly when `cstate` == ON; it depends only on `cstate`, never directly on j or k.
  - Latency: one clock edge from sampled inputs to the out change.
- `nstate` follows input changes within the same cycle and is visible before the next edge.
- Unknown or illegal `cstate` encoding: the default branch drives `nstate` to OFF and out to 0.
- Reset asserted mid-operation returns the machine to OFF asynchronously, regardless of j and k.
- No latches:
  - The combinational block assigns `nstate` on every path.
  - `nstate` defaults to `cstate` before the case statement.

Test Plan:
- Hold sys_rst_n=0 for 20 ns with j=0, k=0 → `cstate`=OFF, out=0 throughout, including across clock edges.
- After release, apply j=1, k=0 for one cycle → `nstate`=ON in the same cycle; out=1 after the next rising edge.
- Apply j=0, k=0 while ON → state holds ON, out stays 1.
- Apply j=1, k=1 while ON → `nstate`=OFF; out=0 after the next edge. Applying j=1, k=1 from OFF instead → out=1 after the next edge.
- Apply j=0, k=1 while OFF → stays OFF, out=0.
  - Full sequence {j,k} = 10, 00, 11, 01 from reset gives out = 0 → 1 → 1 → 0 → 0, one edge after each input pair.
- With the machine in ON, pull sys_rst_n low between clock edges → out drops to 0 immediately, without waiting for an edge. After release with j=0, out stays 0.
